// File: rtl/namuru_wb_fanout.sv
// Wishbone slave front-end for a Namuru correlator bank: decodes per-channel
// pages plus a control page, times out silent channels, aggregates interrupts.
module namuru_wb_fanout #(
    parameter int NUM_CH  = 4,
    parameter int CH_AW   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    output logic                 wb_ack_o,
    output logic [NUM_CH-1:0]    ch_req_o,
    output logic                 ch_we_o,
    output logic [CH_AW-1:0]     ch_adr_o,
    output logic [31:0]          ch_dat_o,
    output logic [3:0]           ch_sel_o,
    input  logic [NUM_CH*32-1:0] ch_dat_i,
    input  logic [NUM_CH-1:0]    ch_ack_i,
    input  logic [NUM_CH-1:0]    ch_irq_i,
    output logic                 irq_o
);

    typedef enum logic [1:0] {IDLE, CHREQ, ACK} state_t;

    localparam logic [3:0]       CTRL_PG = 4'(NUM_CH);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CH_AW-1:0] W_PEND  = CH_AW'(0);
    localparam logic [CH_AW-1:0] W_MASK  = CH_AW'(1);
    localparam logic [CH_AW-1:0] W_ERR   = CH_AW'(2);
    localparam logic [CH_AW-1:0] W_INFO  = CH_AW'(3);

    state_t              state_q;
    logic [CH_AW-1:0]    adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                we_q;
    logic [NUM_CH-1:0]   req_q;
    logic [31:0]         rdat_q;
    logic                ack_q;
    logic [7:0]          tcnt_q;
    logic [15:0]         err_q;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   prev_q;
    logic                irq_q;

    logic [3:0]          pg;
    logic [CH_AW-1:0]    wd;
    logic                start;
    logic                ctrl_wr;
    logic [31:0]         bmask;
    logic [NUM_CH-1:0]   pg_hot;
    logic [31:0]         ch_rdat;
    logic [31:0]         ctrl_rdat;
    logic                hit_ack;
    logic                unused_adr;

    assign pg         = wb_adr_i[CH_AW+2 +: 4];
    assign wd         = wb_adr_i[CH_AW+1:2];
    assign unused_adr = ^{wb_adr_i[31:CH_AW+6], wb_adr_i[1:0]};
    assign start      = wb_cyc_i & wb_stb_i & (state_q == IDLE);
    assign ctrl_wr    = start & wb_we_i & (pg == CTRL_PG);
    assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                         {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    // req_q is one-hot, so it doubles as the selected-channel mask
    assign hit_ack    = |(ch_ack_i & req_q);

    always_comb begin
        pg_hot  = '0;
        ch_rdat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pg_hot[i] = (pg == 4'(i));
            if (req_q[i]) ch_rdat = ch_rdat | ch_dat_i[32*i +: 32];
        end
    end

    always_comb begin
        ctrl_rdat = '0;
        if (wd == W_PEND) ctrl_rdat = 32'(pend_q);
        if (wd == W_MASK) ctrl_rdat = 32'(mask_q);
        if (wd == W_ERR)  ctrl_rdat = 32'(err_q);
        if (wd == W_INFO) ctrl_rdat = {16'h4E4D, 8'd0, 4'd0, CTRL_PG};
    end

    // A new rising edge overrides a write-1-to-clear on the same cycle
    always_comb begin
        pend_d = pend_q;
        mask_d = mask_q;
        if (ctrl_wr && wd == W_PEND)
            pend_d = pend_q & ~NUM_CH'(wb_dat_i & bmask);
        if (ctrl_wr && wd == W_MASK)
            mask_d = (mask_q & ~NUM_CH'(bmask)) | NUM_CH'(wb_dat_i & bmask);
        pend_d = pend_d | (ch_irq_i & ~prev_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            req_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            tcnt_q  <= '0;
            err_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev_q <= ch_irq_i;
            pend_q <= pend_d;
            mask_q <= mask_d;
            irq_q  <= |(pend_q & mask_q);
            ack_q  <= 1'b0;
            if (ctrl_wr && wd == W_ERR) err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        adr_q  <= wd;
                        dat_q  <= wb_dat_i;
                        sel_q  <= wb_sel_i;
                        we_q   <= wb_we_i;
                        tcnt_q <= '0;
                        if (pg < CTRL_PG) begin
                            req_q   <= pg_hot;
                            state_q <= CHREQ;
                        end else begin
                            rdat_q  <= (pg == CTRL_PG) ? ctrl_rdat : '0;
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end
                    end
                end
                CHREQ: begin
                    if (!wb_cyc_i) begin
                        req_q   <= '0;
                        state_q <= IDLE;
                    end else if (hit_ack) begin
                        rdat_q  <= ch_rdat;
                        req_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end else if (tcnt_q == TO_LAST) begin
                        rdat_q  <= '1;
                        req_q   <= '0;
                        ack_q   <= 1'b1;
                        if (err_q != '1) err_q <= err_q + 16'd1;
                        state_q <= ACK;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign ch_req_o = req_q;
    assign ch_we_o  = we_q;
    assign ch_adr_o = adr_q;
    assign ch_dat_o = dat_q;
    assign ch_sel_o = sel_q;
    assign irq_o    = irq_q;

endmodule
